// File: rtl/hilo_mult_unit.sv
// Shift-add multiplier that owns the HI/LO pair and stalls the datapath until the product commits.
// Optional signed multiply is built in when MULT_SIGNED_EN is defined.
module hilo_mult_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_op,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            stateReg;
    stateT            stateNext;
    logic [W2-1:0]    mcandReg;
    logic [W2-1:0]    accReg;
    logic [WIDTH-1:0] mplierReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [CW-1:0]    countReg;
    logic             busyReg;
    logic             doneReg;

    logic             loadOps;
    logic             stepRun;
    logic             commit;
    logic             lastCycle;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [W2-1:0]    ppTerm [BITS_PER_CYCLE];
    logic [W2-1:0]    partialSum;
    logic [W2-1:0]    accSum;
    logic [W2-1:0]    productFinal;

    // Operand conditioning: magnitudes plus a recorded result sign when signed multiply is built in.
`ifdef MULT_SIGNED_EN
    logic negNext;
    logic negReg;

    always_comb begin
        aMag    = (signed_op && a[WIDTH-1]) ? -a : a;
        bMag    = (signed_op && b[WIDTH-1]) ? -b : b;
        negNext = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    assign productFinal = negReg ? -accSum : accSum;
`else
    logic unusedSignedOp;

    assign unusedSignedOp = signed_op;
    assign aMag           = a;
    assign bMag           = b;
    assign productFinal   = accSum;
`endif

    // One shifted copy of the multiplicand per multiplier bit retired this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : gPartial
            assign ppTerm[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partialSum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partialSum = partialSum + ppTerm[i];
        end
    end

    assign accSum    = accReg + partialSum;
    assign lastCycle = (countReg == CW'(N - 1));

    always_comb begin
        stateNext = stateReg;
        stall     = 1'b0;
        loadOps   = 1'b0;
        stepRun   = 1'b0;
        commit    = 1'b0;
        case (stateReg)
            IDLE: begin
                stall = start & en;
                if (start && en) begin
                    loadOps   = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (en) begin
                    stepRun = 1'b1;
                    if (lastCycle) begin
                        commit    = 1'b1;
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                // The stalled instruction retires here, so start is not looked at.
                if (en) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            mcandReg  <= '0;
            accReg    <= '0;
            mplierReg <= '0;
            countReg  <= '0;
            hiReg     <= '0;
            loReg     <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
`ifdef MULT_SIGNED_EN
            negReg    <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            busyReg  <= (stateNext == RUN);
            doneReg  <= (stateNext == DONE);
            if (loadOps) begin
                mcandReg  <= {{WIDTH{1'b0}}, aMag};
                mplierReg <= bMag;
                accReg    <= '0;
                countReg  <= '0;
`ifdef MULT_SIGNED_EN
                negReg    <= negNext;
`endif
            end else if (stepRun) begin
                accReg    <= accSum;
                mcandReg  <= mcandReg << BITS_PER_CYCLE;
                mplierReg <= mplierReg >> BITS_PER_CYCLE;
                countReg  <= countReg + CW'(1);
            end
            // Final partial product is folded in on the same edge that commits HI/LO.
            if (commit) begin
                hiReg <= productFinal[W2-1:WIDTH];
                loReg <= productFinal[WIDTH-1:0];
            end
        end
    end

    assign busy = busyReg;
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: one-bit and four-bit-per-cycle instances,
// expected products queued at start and compared when done pulses.
module tb_hilo_mult_unit;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, start, signed_op;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    logic        en4, start4, sop4;
    logic [31:0] a4, b4;
    logic        stall4, busy4, done4;
    logic [31:0] hi4, lo4;

    int          passCount = 0;
    int          checkCount = 0;
    logic [63:0] expQ[$];
    logic [31:0] prevHi = '0;
    logic [31:0] prevLo = '0;

    always #5 clk = ~clk;

    hilo_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b), .signed_op(signed_op),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    hilo_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .start(start4), .a(a4), .b(b4), .signed_op(sop4),
        .stall(stall4), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        if (s && SIGNED_BUILD) p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return p;
    endfunction

    task automatic drive_start(input logic [31:0] aa, input logic [31:0] bb, input logic sop);
        @(negedge clk);
        a = aa; b = bb; signed_op = sop; start = 1'b1; en = 1'b1;
        expQ.push_back(model(aa, bb, sop));
        #1;
    endtask

    // Runs the multiply to its done pulse, returning observations only.
    task automatic watch(input int offAt, input int offLen, input bit scramble,
                         output int stalls, output bit gotDone,
                         output logic [31:0] hiSeen, output logic [31:0] loSeen, output bit holdOk);
        stalls  = (stall === 1'b1) ? 1 : 0;
        gotDone = 1'b0;
        holdOk  = 1'b1;
        hiSeen  = 'x;
        loSeen  = 'x;
        for (int c = 1; c <= 200 && !gotDone; c++) begin
            @(negedge clk);
            start = 1'b0;
            en    = (c >= offAt && c < offAt + offLen) ? 1'b0 : 1'b1;
            if (scramble) begin a = $urandom; b = $urandom; end
            #1;
            if (stall === 1'b1) stalls++;
            if (done === 1'b1) begin
                gotDone = 1'b1; hiSeen = hi; loSeen = lo;
            end else if (hi !== prevHi || lo !== prevLo) begin
                holdOk = 1'b0;
            end
        end
    endtask

    task automatic finish_mult(input string name, input int stallsReq, input int offAt, input int offLen,
                               input bit scramble);
        int          stalls;
        bit          gotDone, holdOk;
        logic [31:0] hs, ls;
        logic [63:0] e;
        watch(offAt, offLen, scramble, stalls, gotDone, hs, ls, holdOk);
        e = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
        checkCount++; if (gotDone !== 1'b1) $display("FAIL %s_done: got %b required 1", name, gotDone); else passCount++;
        checkCount++; if (hs !== e[63:32]) $display("FAIL %s_hi: got %h required %h", name, hs, e[63:32]); else passCount++;
        checkCount++; if (ls !== e[31:0]) $display("FAIL %s_lo: got %h required %h", name, ls, e[31:0]); else passCount++;
        checkCount++; if (stalls !== stallsReq) $display("FAIL %s_stalls: got %0d required %0d", name, stalls, stallsReq); else passCount++;
        checkCount++; if (holdOk !== 1'b1) $display("FAIL %s_hold: hi/lo changed before done, required %h_%h", name, prevHi, prevLo); else passCount++;
        $display("txn %s a*b -> hi=%h lo=%h stalls=%0d", name, hs, ls, stalls);
        prevHi = e[63:32];
        prevLo = e[31:0];
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0; a = '0; b = '0; signed_op = 1'b0;
        en4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0; sop4 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkCount++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: got %h_%h required 0_0", hi, lo); else passCount++;
        checkCount++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b required 000", busy, done, stall); else passCount++;
        checkCount++; if (hi4 !== 32'd0 || lo4 !== 32'd0 || busy4 !== 1'b0) $display("FAIL reset_dut4: got %h_%h busy=%b required 0", hi4, lo4, busy4); else passCount++;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        prevHi = '0; prevLo = '0;
        $display("txn reset");
    endtask

    task automatic test_basic;
        drive_start(32'd3, 32'd5, 1'b0);
        finish_mult("basic", 33, 0, 0, 1'b0);
        @(negedge clk); #1;
        checkCount++; if (done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) $display("FAIL done_pulse: got done=%b busy=%b stall=%b required 000", done, busy, stall); else passCount++;
        for (int k = 0; k < 2; k++) begin
            drive_start($urandom, $urandom, 1'b0);
            finish_mult("random", 33, 0, 0, 1'b0);
        end
    endtask

    task automatic test_max_scramble;
        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_mult("max_scramble", 33, 0, 0, 1'b1);
    endtask

    task automatic test_reset_abort;
        drive_start(32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (10) begin @(negedge clk); start = 1'b0; end
        #1;
        checkCount++; if (busy !== 1'b1 || stall !== 1'b1) $display("FAIL abort_running: got busy=%b stall=%b required 11", busy, stall); else passCount++;
        @(negedge clk); rst = 1'b1; en = 1'b0;
        @(negedge clk); #1;
        checkCount++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL abort_hilo: got %h_%h required 0_0", hi, lo); else passCount++;
        checkCount++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_ctrl: got stall=%b busy=%b done=%b required 000", stall, busy, done); else passCount++;
        rst = 1'b0; en = 1'b1;
        expQ.delete();
        prevHi = '0; prevLo = '0;
        $display("txn abort");
        drive_start(32'h0001_0000, 32'h0001_0000, 1'b0);
        finish_mult("after_abort", 33, 0, 0, 1'b0);
    endtask

    task automatic test_en_freeze;
        drive_start(32'h0000_1234, 32'h0000_ABCD, 1'b0);
        finish_mult("en_freeze", 38, 10, 5, 1'b0);
    endtask

    task automatic test_en_gate;
        @(negedge clk);
        en = 1'b0; start = 1'b1; a = 32'd9; b = 32'd9;
        #1;
        checkCount++; if (stall !== 1'b0) $display("FAIL en_gate_stall: got %b required 0", stall); else passCount++;
        @(negedge clk);
        start = 1'b0; en = 1'b1;
        #1;
        checkCount++; if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL en_gate_idle: got busy=%b stall=%b required 00", busy, stall); else passCount++;
        $display("txn en_gate");
    endtask

    task automatic test_back_to_back;
        drive_start(32'd7, 32'd9, 1'b0);
        finish_mult("b2b_first", 33, 0, 0, 1'b0);
        // Still in the DONE cycle: next instruction's start must not be taken here.
        a = 32'h00C0_FFEE; b = 32'h0000_0101; start = 1'b1;
        expQ.push_back(model(32'h00C0_FFEE, 32'h0000_0101, 1'b0));
        #1;
        checkCount++; if (stall !== 1'b0) $display("FAIL b2b_done_stall: got %b required 0", stall); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (busy !== 1'b0 || stall !== 1'b1) $display("FAIL b2b_idle_accept: got busy=%b stall=%b required 01", busy, stall); else passCount++;
        finish_mult("b2b_second", 33, 0, 0, 1'b0);
    endtask

    task automatic test_bpc4;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        va[0] = 32'h1234_5678; vb[0] = 32'h9ABC_DEF0;
        va[1] = $urandom;      vb[1] = $urandom;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            int          stalls;
            bit          gotDone;
            logic [63:0] e;
            logic [31:0] hs, ls;
            @(negedge clk);
            a4 = va[k]; b4 = vb[k]; start4 = 1'b1; en4 = 1'b1; sop4 = 1'b0;
            expQ.push_back(model(va[k], vb[k], 1'b0));
            #1;
            stalls = (stall4 === 1'b1) ? 1 : 0;
            gotDone = 1'b0; hs = 'x; ls = 'x;
            for (int c = 0; c < 50 && !gotDone; c++) begin
                @(negedge clk); start4 = 1'b0; #1;
                if (stall4 === 1'b1) stalls++;
                if (done4 === 1'b1) begin gotDone = 1'b1; hs = hi4; ls = lo4; end
            end
            e = (expQ.size() > 0) ? expQ.pop_front() : 64'hx;
            checkCount++; if (gotDone !== 1'b1) $display("FAIL bpc4_done: got %b required 1", gotDone); else passCount++;
            checkCount++; if ({hs, ls} !== e) $display("FAIL bpc4_product: got %h_%h required %h", hs, ls, e); else passCount++;
            checkCount++; if (stalls !== 9) $display("FAIL bpc4_stalls: got %0d required 9", stalls); else passCount++;
            $display("txn bpc4 %h*%h -> hi=%h lo=%h stalls=%0d", va[k], vb[k], hs, ls, stalls);
        end
    endtask

    task automatic test_signed;
        drive_start(32'hFFFF_FFFF, 32'd2, 1'b1);
        finish_mult("signed_neg", 33, 0, 0, 1'b0);
        checkCount++; if (prevHi !== hi) $display("FAIL signed_hi_view: got %h required %h", hi, prevHi); else passCount++;
        drive_start(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1);
        finish_mult("signed_both", 33, 0, 0, 1'b0);
        drive_start(32'h8000_0000, 32'd3, 1'b1);
        finish_mult("signed_min", 33, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_scramble();
        test_reset_abort();
        test_en_freeze();
        test_en_gate();
        test_back_to_back();
        test_bpc4();
        test_signed();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
